// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: funct3 codes,
// memory-stage FSM encoding and store-lane helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mstate_e;

  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
  } mreq_t;

  // Encodings that are undefined, or unsigned variants used by a store.
  function automatic logic f3_bad(
    input logic [2:0] f3,
    input logic       we
  );
    logic ld_only;
    logic known;
    ld_only = (f3 == F3_BU) || (f3 == F3_HU);
    known   = (f3 == F3_B) || (f3 == F3_H) ||
              (f3 == F3_W) || ld_only;
    return !known || (ld_only && we);
  endfunction

  function automatic logic misal(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic h;
    logic w;
    h = (f3 == F3_H) || (f3 == F3_HU);
    w = (f3 == F3_W);
    return (h && off[0]) || (w && (off != 2'b00));
  endfunction

  // Size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] be_of(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      f3[1:0] == 2'b00: be = 4'b0001 << off;
      f3[1:0] == 2'b01: be = off[1] ? 4'b1100 : 4'b0011;
      default:          be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wd_of(
    input logic [2:0]  f3,
    input logic [31:0] b
  );
    logic [31:0] wd;
    wd = b;
    unique case (1'b1)
      f3[1:0] == 2'b00: wd = {4{b[7:0]}};
      f3[1:0] == 2'b01: wd = {2{b[15:0]}};
      default:          wd = b;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data aligner: picks the byte/halfword at the
// access offset and sign- or zero-extends it.
module load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] drdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] fmt
);

  logic [7:0]  b;
  logic [15:0] h;

  assign h = offset[1] ? drdata[31:16] : drdata[15:0];

  // Byte lane select
  always_comb begin
    b = drdata[7:0];
    unique case (offset)
      2'd0: b = drdata[7:0];
      2'd1: b = drdata[15:8];
      2'd2: b = drdata[23:16];
      2'd3: b = drdata[31:24];
    endcase
  end

  // Extension by access type; words pass through
  always_comb begin
    fmt = drdata;
    unique case (1'b1)
      funct3 == F3_B:  fmt = {{24{b[7]}}, b};
      funct3 == F3_BU: fmt = {24'h0, b};
      funct3 == F3_H:  fmt = {{16{h[15]}}, h};
      funct3 == F3_HU: fmt = {16'h0, h};
      default:         fmt = drdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 memory stage: load/store to handshaked data bus,
// with stall, load formatting and fault/timeout pulses.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 255,
  parameter int unsigned TMO_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [2:0]  mfunct3,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        mfault,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic        dgnt,
  input  logic        drvalid,
  input  logic [31:0] drdata
);

  localparam bit             TEN  = (TMO_CYCLES != 0);
  localparam logic [TMO_W:0] TLIM = TMO_CYCLES[TMO_W:0];
  localparam logic [TMO_W:0] ONE  = {{TMO_W{1'b0}}, 1'b1};

  mstate_e          st;
  mreq_t            rq;
  logic [TMO_W-1:0] tcnt;
  logic [TMO_W:0]   tnext;
  logic             acc;
  logic             bad;
  logic             ok;
  logic             tmo;
  logic             ld_done;
  logic [31:0]      fmt;

  assign acc = mwmem ^ mm2reg;
  assign bad = (mwmem & mm2reg) |
               (acc & (f3_bad(mfunct3, mwmem) |
                       misal(mfunct3, malu[1:0])));
  assign ok  = acc & ~bad;

  assign mstall = ((st == ST_IDLE) & ok) |
                  (st == ST_REQ) | (st == ST_WAIT);

  // tnext is the count after this cycle; >= keeps the
  // abort sticky across the REQ->WAIT hand-off.
  assign tnext = {1'b0, tcnt} + ONE;
  assign tmo   = TEN && (tnext >= TLIM);

  assign ld_done = ~dwe & drvalid &
                   (((st == ST_REQ) & dgnt) | (st == ST_WAIT));

  load_formatter u_fmt (
    .drdata (drdata),
    .offset (rq.off),
    .funct3 (rq.f3),
    .fmt    (fmt)
  );

  // Access FSM with registered bus outputs and fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      rq     <= '0;
      tcnt   <= '0;
      dreq   <= 1'b0;
      dwe    <= 1'b0;
      daddr  <= '0;
      dbe    <= '0;
      dwdata <= '0;
      mmo    <= '0;
      mfault <= 1'b0;
    end else begin
      mfault <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (ok) begin
            rq.f3  <= mfunct3;
            rq.off <= malu[1:0];
            dreq   <= 1'b1;
            dwe    <= mwmem;
            daddr  <= {malu[31:2], 2'b00};
            dbe    <= be_of(mfunct3, malu[1:0]);
            dwdata <= wd_of(mfunct3, mb);
            tcnt   <= '0;
            st     <= ST_REQ;
          end else if (bad) begin
            mfault <= 1'b1;
          end
        end
        ST_REQ: begin
          tcnt <= tnext[TMO_W-1:0];
          if (dgnt) begin
            dreq <= 1'b0;
            if (ld_done) mmo <= fmt;
            st <= (dwe || drvalid) ? ST_DONE : ST_WAIT;
          end else if (tmo) begin
            dreq   <= 1'b0;
            mfault <= 1'b1;
            st     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          tcnt <= tnext[TMO_W-1:0];
          if (ld_done) begin
            mmo <= fmt;
            st  <= ST_DONE;
          end else if (tmo) begin
            mfault <= 1'b1;
            st     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
